// File: rtl/infix_pkg.sv
// Shared definitions for the infix-to-postfix tokenizer.
// Contents: token width, ASCII operator codes, controller state encoding,
// operator precedence and operator classification helpers.
package infix_pkg;

  localparam int TOK_W = 8;

  localparam logic [TOK_W-1:0] CH_ADD = 8'h2B;  // '+'
  localparam logic [TOK_W-1:0] CH_SUB = 8'h2D;  // '-'
  localparam logic [TOK_W-1:0] CH_MUL = 8'h2A;  // '*'
  localparam logic [TOK_W-1:0] CH_DIV = 8'h2F;  // '/'
  localparam logic [TOK_W-1:0] CH_LP  = 8'h28;  // '('
  localparam logic [TOK_W-1:0] CH_RP  = 8'h29;  // ')'

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP_PREC  = 3'd1,
    ST_POP_PAREN = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  // '(' maps to 0 so that it never qualifies for popping against any operator.
  function automatic logic [1:0] prec(input logic [TOK_W-1:0] op);
    case (op)
      CH_MUL, CH_DIV: prec = 2'd2;
      CH_ADD, CH_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [TOK_W-1:0] op);
    case (op)
      CH_ADD, CH_SUB, CH_MUL, CH_DIV: is_arith = 1'b1;
      default:                        is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/infix_tokenizer_shunt_if.sv
// Token-in / postfix-out bundle of the infix tokenizer.
// master: token producer (drives IN_*, observes everything else).
// slave : the tokenizer (consumes IN_*, drives BUSY, outputs, strobes, ERR).
interface infix_tokenizer_shunt_if;
  import infix_pkg::*;

  logic [TOK_W-1:0] IN_DATA;
  logic             IN_IS_OP;
  logic             IN_STB;
  logic             IN_END;
  logic             BUSY;
  logic [TOK_W-1:0] OUT_NUMBER;
  logic             NUMBER_STB;
  logic [TOK_W-1:0] OUT_SIGN;
  logic             SIGN_STB;
  logic             END_STB;
  logic             ERR;

  modport master (
    output IN_DATA, IN_IS_OP, IN_STB, IN_END,
    input  BUSY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, END_STB, ERR
  );

  modport slave (
    input  IN_DATA, IN_IS_OP, IN_STB, IN_END,
    output BUSY, OUT_NUMBER, NUMBER_STB, OUT_SIGN, SIGN_STB, END_STB, ERR
  );

endinterface

// File: rtl/op_stack.sv
// Operator LIFO, OP_DEPTH entries of TOK_W bits.
// Ports: CLK, RST (async active-low), push/push_data, pop, top (current top,
// valid when !empty, read in the same cycle as the pop), empty, full.
// Push into a full stack and pop from an empty stack are ignored; the
// controller never requests push and pop together.
module op_stack
  import infix_pkg::*;
#(
  parameter int OP_DEPTH = 16,
  parameter int PTR_W    = $clog2(OP_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [TOK_W-1:0] push_data,
  output logic [TOK_W-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int IDX_W = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;

  logic [TOK_W-1:0] mem_r [OP_DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign empty    = (ptr_r == '0);
  assign full     = (ptr_r == PTR_W'(OP_DEPTH));
  assign wr_idx_s = ptr_r[IDX_W-1:0];
  assign rd_idx_s = wr_idx_s - IDX_W'(1);

  // Stack pointer: counts entries, guarded so it never wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_r <= '0;
    end else if (push && !full) begin
      ptr_r <= ptr_r + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr_r <= ptr_r - PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Entry storage, written at the current pointer on push.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < OP_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !full) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

  // Top-of-stack read; forced to zero when there is nothing stored.
  always_comb begin
    if (empty) begin
      top = '0;
    end else begin
      top = mem_r[rd_idx_s];
    end
  end

endmodule

// File: rtl/infix_tokenizer_shunt.sv
// Shunting-yard reorderer: infix tokens in, postfix numbers/operators out.
// Ports: CLK, RST (async active-low), bus (slave side of
// infix_tokenizer_shunt_if: IN_DATA/IN_IS_OP/IN_STB/IN_END in; BUSY,
// OUT_NUMBER/NUMBER_STB, OUT_SIGN/SIGN_STB, END_STB, ERR out, all registered).
// An END seen alone in IDLE performs the first drain step in that same cycle,
// so the first drained operator follows END with one cycle of latency.
module infix_tokenizer_shunt
  import infix_pkg::*;
#(
  parameter int OP_DEPTH = 16,
  parameter int PTR_W    = $clog2(OP_DEPTH + 1)
) (
  input logic                 CLK,
  input logic                 RST,
  infix_tokenizer_shunt_if.slave bus
);

  state_t           state_r, state_nx_s;
  logic [TOK_W-1:0] op_latch_r, op_latch_nx_s;
  logic             end_pend_r, end_pend_nx_s;

  logic             push_s, pop_s;
  logic [TOK_W-1:0] push_data_s;
  logic [TOK_W-1:0] top_s;
  logic             empty_s, full_s;

  logic             num_stb_s, sign_stb_s, end_stb_s;
  logic             qual_in_s, qual_latch_s;
  state_t           after_tok_s, resume_s;

  logic [TOK_W-1:0] out_number_r, out_sign_r;
  logic             number_stb_r, sign_stb_r, end_stb_r, busy_r, err_r;

  op_stack #(
    .OP_DEPTH (OP_DEPTH),
    .PTR_W    (PTR_W)
  ) u_stack (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .top       (top_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // "Top qualifies": non-empty, not a '(' barrier, and binds at least as tight.
  assign qual_in_s    = !empty_s && (top_s != CH_LP) && (prec(top_s) >= prec(bus.IN_DATA));
  assign qual_latch_s = !empty_s && (top_s != CH_LP) && (prec(top_s) >= prec(op_latch_r));

  // Where to go once a token finishes: straight into the drain if END came with it.
  assign after_tok_s = bus.IN_END ? ST_DRAIN : ST_IDLE;
  assign resume_s    = end_pend_r ? ST_DRAIN : ST_IDLE;

  // Next-state, stack control and strobe decisions.
  always_comb begin
    state_nx_s    = state_r;
    op_latch_nx_s = op_latch_r;
    end_pend_nx_s = end_pend_r;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    push_data_s   = '0;
    num_stb_s     = 1'b0;
    sign_stb_s    = 1'b0;
    end_stb_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.IN_STB) begin
          if (!bus.IN_IS_OP) begin
            num_stb_s  = 1'b1;
            state_nx_s = after_tok_s;
          end else if (bus.IN_DATA == CH_LP) begin
            if (full_s) begin
              state_nx_s = ST_ERROR;
            end else begin
              push_s      = 1'b1;
              push_data_s = bus.IN_DATA;
              state_nx_s  = after_tok_s;
            end
          end else if (is_arith(bus.IN_DATA)) begin
            if (qual_in_s) begin
              pop_s         = 1'b1;
              sign_stb_s    = 1'b1;
              op_latch_nx_s = bus.IN_DATA;
              end_pend_nx_s = bus.IN_END;
              state_nx_s    = ST_POP_PREC;
            end else if (full_s) begin
              state_nx_s = ST_ERROR;
            end else begin
              push_s      = 1'b1;
              push_data_s = bus.IN_DATA;
              state_nx_s  = after_tok_s;
            end
          end else if (bus.IN_DATA == CH_RP) begin
            if (empty_s) begin
              state_nx_s = ST_ERROR;
            end else if (top_s == CH_LP) begin
              pop_s      = 1'b1;
              state_nx_s = after_tok_s;
            end else begin
              pop_s         = 1'b1;
              sign_stb_s    = 1'b1;
              end_pend_nx_s = bus.IN_END;
              state_nx_s    = ST_POP_PAREN;
            end
          end else begin
            state_nx_s = ST_ERROR;
          end
        end else if (bus.IN_END) begin
          // First drain step happens right away.
          if (empty_s) begin
            end_stb_s = 1'b1;
          end else if (top_s == CH_LP) begin
            state_nx_s = ST_ERROR;
          end else begin
            pop_s      = 1'b1;
            sign_stb_s = 1'b1;
            state_nx_s = ST_DRAIN;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_POP_PREC: begin
        if (qual_latch_s) begin
          pop_s      = 1'b1;
          sign_stb_s = 1'b1;
        end else if (full_s) begin
          state_nx_s = ST_ERROR;
        end else begin
          push_s        = 1'b1;
          push_data_s   = op_latch_r;
          end_pend_nx_s = 1'b0;
          state_nx_s    = resume_s;
        end
      end

      ST_POP_PAREN: begin
        if (empty_s) begin
          state_nx_s = ST_ERROR;
        end else if (top_s == CH_LP) begin
          pop_s         = 1'b1;
          end_pend_nx_s = 1'b0;
          state_nx_s    = resume_s;
        end else begin
          pop_s      = 1'b1;
          sign_stb_s = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (empty_s) begin
          end_stb_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (top_s == CH_LP) begin
          state_nx_s = ST_ERROR;
        end else begin
          pop_s      = 1'b1;
          sign_stb_s = 1'b1;
        end
      end

      ST_ERROR: begin
        state_nx_s = ST_ERROR;
      end

      default: begin
        state_nx_s = ST_ERROR;
      end
    endcase
  end

  // Controller state and registered outputs; data outputs hold between strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      op_latch_r   <= '0;
      end_pend_r   <= 1'b0;
      out_number_r <= '0;
      out_sign_r   <= '0;
      number_stb_r <= 1'b0;
      sign_stb_r   <= 1'b0;
      end_stb_r    <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      op_latch_r   <= op_latch_nx_s;
      end_pend_r   <= end_pend_nx_s;
      number_stb_r <= num_stb_s;
      sign_stb_r   <= sign_stb_s;
      end_stb_r    <= end_stb_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      err_r        <= (state_nx_s == ST_ERROR);
      if (num_stb_s) begin
        out_number_r <= bus.IN_DATA;
      end
      if (sign_stb_s) begin
        out_sign_r <= top_s;
      end
    end
  end

  assign bus.OUT_NUMBER = out_number_r;
  assign bus.NUMBER_STB = number_stb_r;
  assign bus.OUT_SIGN   = out_sign_r;
  assign bus.SIGN_STB   = sign_stb_r;
  assign bus.END_STB    = end_stb_r;
  assign bus.BUSY       = busy_r;
  assign bus.ERR        = err_r;

endmodule

// File: tb/tb_infix_tokenizer_shunt.sv
`timescale 1ns/1ps
module tb_infix_tokenizer_shunt;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       is_op;
    logic [7:0] d;
  } tok_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  infix_tokenizer_shunt_if bus ();

  infix_tokenizer_shunt #(.OP_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- observation ----------------
  logic [9:0] obs_q[$];   // {kind, data}: kind 0 number, 1 sign, 2 end
  int         obs_t[$];
  int         cyc = 0;
  int         busy_cnt = 0;
  bit         both_seen, hold_bad;
  logic [7:0] last_num = 8'h00, last_sign = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.NUMBER_STB === 1'b1) begin
      obs_q.push_back({2'd0, bus.OUT_NUMBER});
      obs_t.push_back(cyc);
      last_num = bus.OUT_NUMBER;
    end else if (bus.OUT_NUMBER !== last_num) begin
      hold_bad = 1'b1;
    end
    if (bus.SIGN_STB === 1'b1) begin
      obs_q.push_back({2'd1, bus.OUT_SIGN});
      obs_t.push_back(cyc);
      last_sign = bus.OUT_SIGN;
    end else if (bus.OUT_SIGN !== last_sign) begin
      hold_bad = 1'b1;
    end
    if (bus.END_STB === 1'b1) begin
      obs_q.push_back({2'd2, 8'h00});
      obs_t.push_back(cyc);
    end
    if (bus.NUMBER_STB === 1'b1 && bus.SIGN_STB === 1'b1) both_seen = 1'b1;
    if (bus.BUSY === 1'b1) busy_cnt++;
  end

  // ---------------- reference model ----------------
  logic [9:0] exp_q[$];
  bit         exp_err;

  function automatic int prec_of(input logic [7:0] c);
    if (c == 8'h2A || c == 8'h2F) return 2;
    if (c == 8'h2B || c == 8'h2D) return 1;
    return 0;
  endfunction

  function automatic bit arith(input logic [7:0] c);
    return (c == 8'h2A || c == 8'h2F || c == 8'h2B || c == 8'h2D);
  endfunction

  task automatic model(input tok_t toks[$]);
    logic [7:0] st[$];
    exp_q.delete();
    exp_err = 1'b0;
    foreach (toks[i]) begin
      if (!toks[i].is_op) begin
        exp_q.push_back({2'd0, toks[i].d});
      end else if (toks[i].d == 8'h28) begin
        if (st.size() == DEPTH) exp_err = 1'b1;
        else st.push_back(toks[i].d);
      end else if (arith(toks[i].d)) begin
        while (st.size() > 0 && st[$] != 8'h28 && prec_of(st[$]) >= prec_of(toks[i].d))
          exp_q.push_back({2'd1, st.pop_back()});
        if (st.size() == DEPTH) exp_err = 1'b1;
        else st.push_back(toks[i].d);
      end else if (toks[i].d == 8'h29) begin
        forever begin
          if (st.size() == 0) begin exp_err = 1'b1; break; end
          if (st[$] == 8'h28) begin void'(st.pop_back()); break; end
          exp_q.push_back({2'd1, st.pop_back()});
        end
      end else begin
        exp_err = 1'b1;
      end
      if (exp_err) return;
    end
    while (st.size() > 0) begin
      if (st[$] == 8'h28) begin exp_err = 1'b1; return; end
      exp_q.push_back({2'd1, st.pop_back()});
    end
    exp_q.push_back({2'd2, 8'h00});
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic tok_t N(input logic [7:0] v); return '{is_op: 1'b0, d: v}; endfunction
  function automatic tok_t O(input logic [7:0] c); return '{is_op: 1'b1, d: c}; endfunction

  int timeouts = 0;
  int base_cyc = 0;
  int busy_pre = 0;

  task automatic apply_reset();
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check_eq("reset_outputs", {bus.BUSY, bus.ERR, bus.NUMBER_STB, bus.SIGN_STB, bus.END_STB,
                               bus.OUT_NUMBER, bus.OUT_SIGN}, 32'h0);
    last_num  = 8'h00;
    last_sign = 8'h00;
    obs_q.delete();
    obs_t.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
  endtask

  // Presents one input beat once BUSY is low; ok=0 if ERR is already set.
  task automatic drive(input logic stb, input tok_t t, input logic endf, output bit ok);
    int budget = 100;
    ok = 1'b1;
    @(negedge CLK);
    while (bus.BUSY && !bus.ERR && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    if (bus.ERR) begin ok = 1'b0; return; end
    if (budget == 0) begin timeouts++; ok = 1'b0; return; end
    bus.IN_DATA  = t.d;
    bus.IN_IS_OP = t.is_op;
    bus.IN_STB   = stb;
    bus.IN_END   = endf;
    @(posedge CLK);
    #1;
    bus.IN_STB   = 1'b0;
    bus.IN_END   = 1'b0;
    bus.IN_IS_OP = 1'b0;
    bus.IN_DATA  = 8'h00;
  endtask

  task automatic run_expr(input string name, input tok_t toks[$], input bit end_same);
    bit ok = 1'b1;
    int n;
    apply_reset();
    model(toks);
    busy_cnt  = 0;
    both_seen = 1'b0;
    hold_bad  = 1'b0;
    timeouts  = 0;
    for (int i = 0; i < toks.size(); i++) begin
      drive(1'b1, toks[i], end_same && (i == toks.size() - 1), ok);
      if (!ok) break;
      if (i == 0) base_cyc = cyc;
    end
    busy_pre = busy_cnt;
    if (ok && (!end_same || toks.size() == 0)) drive(1'b0, N(8'h00), 1'b1, ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (bus.END_STB || bus.ERR) begin ok = 1'b1; break; end
    end
    if (!ok) timeouts++;
    repeat (3) @(negedge CLK);
    check_eq({name, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_tok%0d", name, i), obs_q[i], exp_q[i]);
    check_eq({name, "_err"}, bus.ERR, exp_err);
    check_eq({name, "_both_strobes"}, both_seen, 1'b0);
    check_eq({name, "_data_hold"}, hold_bad, 1'b0);
    check_eq({name, "_timeouts"}, timeouts, 0);
  endtask

  task automatic gen_random(output tok_t q[$]);
    int len = $urandom_range(1, 10);
    int r;
    q.delete();
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       q.push_back(O(8'h30 + 8'($urandom_range(0, 9))));
      else if (r < 45) q.push_back(N(8'($urandom_range(0, 255))));
      else if (r < 73) begin
        case ($urandom_range(0, 3))
          0:       q.push_back(O(8'h2B));
          1:       q.push_back(O(8'h2D));
          2:       q.push_back(O(8'h2A));
          default: q.push_back(O(8'h2F));
        endcase
      end
      else if (r < 88) q.push_back(O(8'h28));
      else             q.push_back(O(8'h29));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tok_t q[$];
    bit   ok;
    int   exp_rel[6] = '{1, 3, 5, 6, 7, 8};
    bus.IN_DATA  = 8'h00;
    bus.IN_IS_OP = 1'b0;
    bus.IN_STB   = 1'b0;
    bus.IN_END   = 1'b0;
    #1;

    // 3 + 4 * 2 with exact output timing.
    q = {N(8'd3), O(8'h2B), N(8'd4), O(8'h2A), N(8'd2)};
    run_expr("prec", q, 1'b0);
    check_eq("prec_count", obs_t.size(), 6);
    for (int i = 0; i < 6 && i < obs_t.size(); i++)
      check_eq($sformatf("prec_cycle%0d", i), obs_t[i] - base_cyc + 1, exp_rel[i]);

    // (1 + 2) * 3
    q = {O(8'h28), N(8'd1), O(8'h2B), N(8'd2), O(8'h29), O(8'h2A), N(8'd3)};
    run_expr("paren", q, 1'b0);

    // 8 - 3 - 2: left associativity, one POP_PREC cycle.
    q = {N(8'd8), O(8'h2D), N(8'd3), O(8'h2D), N(8'd2)};
    run_expr("leftassoc", q, 1'b0);
    check_eq("leftassoc_busy_cycles", busy_pre, 1);

    // 5 ) -> error, then a number is ignored.
    q = {N(8'd5), O(8'h29)};
    run_expr("unmatched", q, 1'b0);
    @(negedge CLK);
    bus.IN_DATA = 8'd7; bus.IN_IS_OP = 1'b0; bus.IN_STB = 1'b1;
    @(posedge CLK); #1;
    bus.IN_STB = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("err_ignores_input", obs_q.size(), 1);
    check_eq("err_sticky", bus.ERR, 1'b1);

    // Overflow on the fifth '(' and leftover '(' during drain.
    q = {O(8'h28), O(8'h28), O(8'h28), O(8'h28), O(8'h28)};
    run_expr("overflow", q, 1'b0);
    q = {O(8'h28), O(8'h28), O(8'h28), O(8'h28), O(8'h29), O(8'h29)};
    run_expr("leftover", q, 1'b0);
    q = {N(8'd9), O(8'h2A), O(8'h28), N(8'd1), O(8'h2D), N(8'd4), O(8'h29)};
    run_expr("end_same", q, 1'b1);

    // Reset in the middle of a drain, then a clean expression.
    apply_reset();
    q = {N(8'd1), O(8'h2B), N(8'd2), O(8'h2A), N(8'd3), O(8'h2A), N(8'd4)};
    foreach (q[i]) drive(1'b1, q[i], 1'b0, ok);
    drive(1'b0, N(8'h00), 1'b1, ok);
    check_eq("middrain_sign_before_reset", bus.SIGN_STB, 1'b1);
    apply_reset();
    repeat (5) @(negedge CLK);
    check_eq("middrain_no_end", obs_q.size(), 0);
    q = {N(8'd6)};
    run_expr("after_reset", q, 1'b0);

    // Randomized expressions against the model.
    for (int e = 0; e < 150; e++) begin
      gen_random(q);
      run_expr($sformatf("rnd%0d", e), q, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
